// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: FIFO of ALU results {result, overflow, func} with overflow tracking.
// Optional macro ALU_WB_BUFFER_BYPASS_EN lets the input pass straight through to
// the output when the FIFO is empty and the consumer is ready.
module alu_wb_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_result,
   input  logic                       in_overflow,
   input  logic [3:0]                 in_func,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_result,
   output logic                       out_overflow,
   output logic [3:0]                 out_func,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       sticky_ovf,
   input  logic                       clear_sticky,
   output logic [7:0]                 ovf_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
   state_t state, state_d;
   logic [DATA_WIDTH-1:0] mem_result [DEPTH];
   logic                  mem_ovf    [DEPTH];
   logic [3:0]            mem_func   [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_d;
   logic fifo_valid, bypass, accept, push, pop, ovf_push;
   assign in_ready   = state != FULL;
   assign fifo_valid = state != EMPTY;
   assign accept     = in_valid && in_ready;
   assign push       = accept && !bypass;
   assign pop        = fifo_valid && out_ready;
   assign ovf_push   = accept && in_overflow;
   assign count_d    = count + (AW+1)'(push) - (AW+1)'(pop);
`ifdef ALU_WB_BUFFER_BYPASS_EN
   assign bypass       = !fifo_valid && in_valid && out_ready;
   assign out_valid    = fifo_valid || bypass;
   assign out_result   = bypass ? in_result   : fifo_valid ? mem_result[rd_ptr] : '0;
   assign out_overflow = bypass ? in_overflow : fifo_valid && mem_ovf[rd_ptr];
   assign out_func     = bypass ? in_func     : fifo_valid ? mem_func[rd_ptr] : 4'd0;
`else
   assign bypass       = 1'b0;
   assign out_valid    = fifo_valid;
   assign out_result   = fifo_valid ? mem_result[rd_ptr] : '0;
   assign out_overflow = fifo_valid && mem_ovf[rd_ptr];
   assign out_func     = fifo_valid ? mem_func[rd_ptr] : 4'd0;
`endif
   // next occupancy state follows the post-update count
   always_comb begin
      state_d = count_d == '0 ? EMPTY : count_d == FULL_CNT ? FULL : PARTIAL;
   end
   // occupancy state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= EMPTY;
      else state <= state_d;
   end
   // pointers and count; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count_d;
      end
   end
   // entry storage; contents are masked at the output while empty so no reset needed
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_result[wr_ptr] <= in_result;
         mem_ovf[wr_ptr]    <= in_overflow;
         mem_func[wr_ptr]   <= in_func;
      end
   end
   // sticky overflow: a new overflow wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (!reset_n) sticky_ovf <= 1'b0;
      else if (ovf_push) sticky_ovf <= 1'b1;
      else if (clear_sticky) sticky_ovf <= 1'b0;
   end
   // saturating overflow counter; clear with a coincident overflow restarts at 1
   always_ff @(posedge clk) begin
      if (!reset_n) ovf_count <= 8'd0;
      else if (clear_sticky) ovf_count <= {7'd0, ovf_push};
      else if (ovf_push && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
   end
endmodule

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, result width matching the ALU data width; DEPTH, 4, FIFO entries (power of two, >=2).
REQ-002 Ports SHALL be as follows; one clock, reset synchronous and active-low:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  ALU result offered
- in_result  in  DATA_WIDTH  ALU C output
- in_overflow  in  1  ALU OverflowFlag
- in_func  in  4  FuncCode that produced the result
- in_ready  out  1  buffer can accept
- out_valid  out  1  head entry available
- out_result  out  DATA_WIDTH  head result
- out_overflow  out  1  head overflow flag
- out_func  out  4  head FuncCode
- out_ready  in  1  consumer accepts head
- count  out  clog2(DEPTH)+1  occupied entries
- sticky_ovf  out  1  overflow seen since clear
- clear_sticky  in  1  clears sticky_ovf
- ovf_count  out  8  number of accepted results with overflow, saturating

Function
REQ-003 Block SHALL buffer ALU results downstream of the ALU in a DEPTH-entry FIFO, each entry {result, overflow, func}.
REQ-004 Push SHALL occur on a rising clk edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-005 in_ready SHALL equal (count != DEPTH), registered-derived, with no combinational dependence on out_ready.
REQ-006 out_valid SHALL equal (count != 0); out_result/out_overflow/out_func SHALL show the head entry and stay stable while out_valid && !out_ready.
REQ-007 Push-to-out_valid latency SHALL be 1 cycle when the FIFO is empty (macro off).
REQ-008 Simultaneous push and pop SHALL leave count unchanged; allowed when full (pop frees the slot only the next cycle, so in_ready stays 0 that cycle) and when empty (push only).
REQ-009 Read/write pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH nor go below 0.
REQ-010 in_valid while full SHALL be ignored with no state change; out_ready while empty SHALL be ignored.
REQ-011 sticky_ovf SHALL set the cycle after any push with in_overflow=1; clear_sticky SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-012 ovf_count SHALL increment by 1 on each push with in_overflow=1 and saturate at 255; clear_sticky SHALL zero it (a simultaneous overflow push yields 1).
REQ-013 Internal states SHALL be EMPTY, PARTIAL, FULL, derived from count; transitions only on push/pop as above.

Reset
REQ-014 When reset_n=0 at a rising clk edge: pointers, count, sticky_ovf, ovf_count SHALL go to 0; out_valid=0; in_ready=1 the next cycle.
REQ-015 Reset mid-operation SHALL discard all buffered entries; a push coinciding with reset SHALL be dropped.
REQ-016 out_result, out_overflow, out_func SHALL read 0 while empty after reset.

Configuration
REQ-017 Macro ALU_WB_BUFFER_BYPASS_EN: when defined, if FIFO is empty and in_valid && out_ready, the input SHALL appear combinationally on out_* with out_valid=1 and SHALL NOT be stored (count unchanged); sticky_ovf and ovf_count still update.
REQ-018 Without ALU_WB_BUFFER_BYPASS_EN, no combinational in->out path SHALL exist; minimum latency is 1 cycle.

Verification
REQ-019 Reset, then push 0x0001,0x0002,0x0003,0x0004 with out_ready=0 -> count=4, in_ready=0; fifth push 0x0005 ignored; then out_ready=1 -> pops 1,2,3,4 in order, count returns to 0.
REQ-020 Push 0x7FFF+1 result 0x8000 with in_overflow=1, func=0000 -> sticky_ovf=1, ovf_count=1 next cycle; clear_sticky same cycle as another overflow push -> sticky_ovf=1, ovf_count=1.
REQ-021 Full FIFO, simultaneous push 0xAAAA and pop -> push ignored since in_ready=0; count=3 next cycle; back-to-back push/pop with count=2 for 10 cycles -> count stays 2, data order preserved across pointer wrap.
REQ-022 Assert reset_n=0 with count=3 and in_valid=1 -> count=0, out_valid=0, sticky_ovf=0, ovf_count=0 next cycle.
REQ-023 300 overflow pushes with out_ready=1 -> ovf_count=255 saturated.
REQ-024 With ALU_WB_BUFFER_BYPASS_EN, empty FIFO, in_valid=1, out_ready=1, in_result=0x1234 -> out_valid=1, out_result=0x1234 same cycle, count stays 0; without macro -> appears next cycle.
